// File: rtl/vga_fetch_pkg.sv
// -----------------------------------------------------------------------------
// vga_fetch_pkg
// Shared types and helpers for the VGA frame-buffer fetch stage:
//   fetch_state_e    - SRAM access sequencer states
//   PIPE_LATENCY     - fixed read latency (address edge to colour edge)
//   rgb565_to_rgb30  - RGB565 to 3x10-bit colour expansion by bit replication
// -----------------------------------------------------------------------------
package vga_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_SETUP  = 2'd1,
    WR_STROBE = 2'd2,
    WR_HOLD   = 2'd3
  } fetch_state_e;

  localparam int PIPE_LATENCY = 2;

  // Replicating the top bits into the low bits maps full-scale 5/6-bit values
  // to full-scale 10-bit values (0x1F -> 0x3FF, 0x3F -> 0x3FF).
  function automatic logic [29:0] rgb565_to_rgb30(input logic [15:0] pix);
    return {pix[15:11], pix[15:11],
            pix[10:5],  pix[10:7],
            pix[4:0],   pix[4:0]};
  endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// -----------------------------------------------------------------------------
// vga_wr_fifo
// Synchronous FIFO buffering host writes until the SRAM is free.
//   mCLK, iRST_N : clock, async active-low reset (pointers/occupancy only)
//   push, wdata  : enqueue one entry (caller guarantees not full)
//   pop          : dequeue head entry (caller guarantees not empty)
//   rdata        : current head entry (combinational)
//   level        : registered occupancy, 0..DEPTH
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module vga_wr_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             mCLK,
  input  logic             iRST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;

  // NOTE: storage array deliberately has no reset; the pointers and count
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge mCLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge mCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;  // idle, or push+pop cancel out
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign level = count;
  assign full  = (count == LVL_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/vga_sram_pixel_fetch.sv
// -----------------------------------------------------------------------------
// vga_sram_pixel_fetch
// Fetches RGB565 pixels from a single-port async SRAM for the VGA controller
// at a fixed 2-cycle latency, and drains host writes into the same SRAM
// whenever the display is not reading.
//   mCLK, iRST_N            : pixel clock, async active-low reset
//   iRead_EN, iAddress      : display pixel request (address sampled this edge)
//   oRed/oGreen/oBlue       : 10-bit expanded colour, valid 2 edges later
//   iWR_Valid/Addr/Data     : host write request into the FIFO
//   oWR_Ready, oFIFO_Level  : FIFO not full / occupancy
//   iClr_Status, oCollision : sticky flag, read requested during a write strobe
//   oSRAM_*, iSRAM_DQ       : SRAM address, data and strobes (DQ tristated above)
// -----------------------------------------------------------------------------
module vga_sram_pixel_fetch
  import vga_fetch_pkg::*;
#(
  parameter  int ADDR_W     = 18,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              mCLK,
  input  logic              iRST_N,
  input  logic              iRead_EN,
  input  logic [19:0]       iAddress,
  output logic [9:0]        oRed,
  output logic [9:0]        oGreen,
  output logic [9:0]        oBlue,
  input  logic              iWR_Valid,
  input  logic [ADDR_W-1:0] iWR_Addr,
  input  logic [15:0]       iWR_Data,
  output logic              oWR_Ready,
  output logic [LVL_W-1:0]  oFIFO_Level,
  input  logic              iClr_Status,
  output logic              oCollision,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  input  logic [15:0]       iSRAM_DQ,
  output logic [15:0]       oSRAM_DQ,
  output logic              oSRAM_DQ_OE,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_CE_N,
  output logic              oSRAM_UB_N,
  output logic              oSRAM_LB_N
);

  // Only the low ADDR_W bits of the pixel address reach the SRAM.
  logic [19:0] unused_addr;
  assign unused_addr = iAddress;

  // ---------------------------------------------------------------- FIFO ----
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W+15:0] fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic [15:0]       head_data;

  assign fifo_push = iWR_Valid && !fifo_full;
  assign oWR_Ready = !fifo_full;
  assign {head_addr, head_data} = fifo_head;

  vga_wr_fifo #(
    .WIDTH (ADDR_W + 16),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .mCLK   (mCLK),
    .iRST_N (iRST_N),
    .push   (fifo_push),
    .wdata  ({iWR_Addr, iWR_Data}),
    .pop    (fifo_pop),
    .rdata  (fifo_head),
    .level  (oFIFO_Level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // ----------------------------------------------------------- Sequencer ----
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              dq_oe_q, dq_oe_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              rd_issue;   // a display read is launched this edge
  logic              collide;    // display read lost to a committed write

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dq_oe_d  = dq_oe_q;
    we_n_d   = we_n_q;
    oe_n_d   = oe_n_q;
    rd_issue = 1'b0;
    collide  = 1'b0;
    fifo_pop = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (iRead_EN) begin
          addr_d   = iAddress[ADDR_W-1:0];
          oe_n_d   = 1'b0;
          dq_oe_d  = 1'b0;
          rd_issue = 1'b1;
        end else if (!fifo_empty) begin
          state_d = WR_SETUP;
          addr_d  = head_addr;
          wdata_d = head_data;
          dq_oe_d = 1'b1;
          oe_n_d  = 1'b1;
        end else begin
          oe_n_d = 1'b1;
        end
      end
      WR_SETUP: begin
        // Nothing has been strobed yet, so the write can yield to the display
        // and simply be retried later; its entry is still in the FIFO.
        if (iRead_EN) begin
          state_d  = IDLE;
          addr_d   = iAddress[ADDR_W-1:0];
          oe_n_d   = 1'b0;
          dq_oe_d  = 1'b0;
          rd_issue = 1'b1;
        end else begin
          state_d = WR_STROBE;
          we_n_d  = 1'b0;
        end
      end
      WR_STROBE: begin
        // The SRAM has latched the write once WE_N rises; retire the entry.
        state_d  = WR_HOLD;
        we_n_d   = 1'b1;
        fifo_pop = 1'b1;
        collide  = iRead_EN;
      end
      WR_HOLD: begin
        state_d = IDLE;
        dq_oe_d = 1'b0;
        collide = iRead_EN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      dq_oe_q <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dq_oe_q <= dq_oe_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
    end
  end

  assign oSRAM_ADDR  = addr_q;
  assign oSRAM_DQ    = wdata_q;
  assign oSRAM_DQ_OE = dq_oe_q;
  assign oSRAM_WE_N  = we_n_q;
  assign oSRAM_OE_N  = oe_n_q;
  assign oSRAM_CE_N  = 1'b0;
  assign oSRAM_UB_N  = 1'b0;
  assign oSRAM_LB_N  = 1'b0;

  // ------------------------------------------------------- Read pipeline ----
  // Edge N: address out. Edge N+1: capture SRAM data. Edge N+2: colour out.
  // The issue flag travels alongside so slots without a read produce black.
  logic [PIPE_LATENCY-1:0] issue_pipe;
  logic [15:0]             dq_q;
  logic [29:0]             rgb_q;

  always_ff @(posedge mCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      issue_pipe <= '0;
      dq_q       <= '0;
      rgb_q      <= '0;
      oCollision <= 1'b0;
    end else begin
      issue_pipe <= {issue_pipe[PIPE_LATENCY-2:0], rd_issue};
      dq_q       <= iSRAM_DQ;
      rgb_q      <= issue_pipe[PIPE_LATENCY-1] ? rgb565_to_rgb30(dq_q) : '0;
      if (collide)          oCollision <= 1'b1;  // set beats clear
      else if (iClr_Status) oCollision <= 1'b0;
    end
  end

  assign {oRed, oGreen, oBlue} = rgb_q;

endmodule

// File: tb/tb_vga_sram_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_vga_sram_pixel_fetch
// Directed bench for vga_sram_pixel_fetch with a behavioural async SRAM.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vga_sram_pixel_fetch;

  localparam int ADDR_W = 18;

  logic              mCLK = 1'b0;
  logic              iRST_N;
  logic              iRead_EN;
  logic [19:0]       iAddress;
  logic [9:0]        oRed, oGreen, oBlue;
  logic              iWR_Valid;
  logic [ADDR_W-1:0] iWR_Addr;
  logic [15:0]       iWR_Data;
  logic              oWR_Ready;
  logic [2:0]        oFIFO_Level;
  logic              iClr_Status;
  logic              oCollision;
  logic [ADDR_W-1:0] oSRAM_ADDR;
  logic [15:0]       iSRAM_DQ;
  logic [15:0]       oSRAM_DQ;
  logic              oSRAM_DQ_OE, oSRAM_WE_N, oSRAM_OE_N;
  logic              oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N;

  always #20 mCLK = ~mCLK;

  vga_sram_pixel_fetch #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .mCLK(mCLK), .iRST_N(iRST_N), .iRead_EN(iRead_EN), .iAddress(iAddress),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .iWR_Valid(iWR_Valid), .iWR_Addr(iWR_Addr), .iWR_Data(iWR_Data),
    .oWR_Ready(oWR_Ready), .oFIFO_Level(oFIFO_Level),
    .iClr_Status(iClr_Status), .oCollision(oCollision),
    .oSRAM_ADDR(oSRAM_ADDR), .iSRAM_DQ(iSRAM_DQ), .oSRAM_DQ(oSRAM_DQ),
    .oSRAM_DQ_OE(oSRAM_DQ_OE), .oSRAM_WE_N(oSRAM_WE_N), .oSRAM_OE_N(oSRAM_OE_N),
    .oSRAM_CE_N(oSRAM_CE_N), .oSRAM_UB_N(oSRAM_UB_N), .oSRAM_LB_N(oSRAM_LB_N)
  );

  // Behavioural async SRAM: combinational read, write latched on WE_N rising.
  logic [15:0] mem [0:1023];
  int          we_pulses = 0;

  assign iSRAM_DQ = oSRAM_OE_N ? 16'h0000 : mem[oSRAM_ADDR[9:0]];

  always @(posedge oSRAM_WE_N)
    if (oSRAM_DQ_OE === 1'b1) mem[oSRAM_ADDR[9:0]] = oSRAM_DQ;

  always @(negedge oSRAM_WE_N) we_pulses++;

  logic [29:0] rgb;
  assign rgb = {oRed, oGreen, oBlue};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the first falling edge at which the sequencer sits in
  // WR_SETUP: data driven, WE_N still high. Call from IDLE only.
  task automatic wait_setup(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge mCLK);
      if (oSRAM_DQ_OE === 1'b1 && oSRAM_WE_N === 1'b1) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  // Waits (bounded) for the FIFO to be empty and the bus released; reports
  // how many sampled cycles had the data bus driven.
  task automatic wait_drain(input string name, output int busy);
    bit found = 1'b0;
    busy = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (oFIFO_Level == 3'd0 && oSRAM_DQ_OE === 1'b0 && oSRAM_WE_N === 1'b1)
        found = 1'b1;
      else begin
        if (oSRAM_DQ_OE === 1'b1) busy++;
        @(negedge mCLK);
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  typedef struct {
    logic        rd;
    logic [19:0] addr;
    logic [29:0] exp_rgb;  // colour expected at this edge, before driving
  } vec_t;

  localparam logic [29:0] RGB_R   = {10'h3FF, 10'h000, 10'h000};
  localparam logic [29:0] RGB_G   = {10'h000, 10'h3FF, 10'h000};
  localparam logic [29:0] RGB_B   = {10'h000, 10'h000, 10'h3FF};
  localparam logic [29:0] RGB_W   = {10'h3FF, 10'h3FF, 10'h3FF};
  localparam logic [29:0] RGB_MID = {10'h210, 10'h208, 10'h210};  // 0x8410
  localparam logic [29:0] RGB_ABC = {10'h2B5, 10'h1E7, 10'h1AD};  // 0xABCD

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int busy;
    int low_cnt;

    // Colour appears three falling edges after the request is driven.
    vecs[0] = '{1'b1, 20'h00010, 30'h0};
    vecs[1] = '{1'b1, 20'h00011, 30'h0};
    vecs[2] = '{1'b1, 20'h00012, 30'h0};
    vecs[3] = '{1'b1, 20'h00013, RGB_R};
    vecs[4] = '{1'b0, 20'h00000, RGB_G};
    vecs[5] = '{1'b1, 20'h00014, RGB_B};
    vecs[6] = '{1'b0, 20'h00000, RGB_W};
    vecs[7] = '{1'b0, 20'h00000, 30'h0};
    vecs[8] = '{1'b0, 20'h00000, RGB_MID};
    vecs[9] = '{1'b0, 20'h00000, 30'h0};

    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h010] = 16'hF800;
    mem[10'h011] = 16'h07E0;
    mem[10'h012] = 16'h001F;
    mem[10'h013] = 16'hFFFF;
    mem[10'h014] = 16'h8410;

    iRST_N = 1'b0; iRead_EN = 1'b0; iAddress = '0;
    iWR_Valid = 1'b0; iWR_Addr = '0; iWR_Data = '0; iClr_Status = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge mCLK);
    check("rst_addr",  32'(oSRAM_ADDR), 32'h0);
    check("rst_dq",    32'(oSRAM_DQ), 32'h0);
    check("rst_dq_oe", 32'(oSRAM_DQ_OE), 32'h0);
    check("rst_we_n",  32'(oSRAM_WE_N), 32'h1);
    check("rst_oe_n",  32'(oSRAM_OE_N), 32'h1);
    check("rst_strb",  32'({oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N}), 32'h0);
    check("rst_rgb",   32'(rgb), 32'h0);
    check("rst_coll",  32'(oCollision), 32'h0);
    check("rst_ready", 32'(oWR_Ready), 32'h1);
    check("rst_level", 32'(oFIFO_Level), 32'h0);
    iRST_N = 1'b1;

    // ---- back-to-back reads and idle slots ----
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rd_vec%0d", i), 32'(rgb), 32'(vecs[i].exp_rgb));
      iRead_EN = vecs[i].rd;
      iAddress = vecs[i].addr;
      @(negedge mCLK);
    end
    iRead_EN = 1'b0;

    // ---- single host write ----
    p0 = we_pulses;
    iWR_Valid = 1'b1; iWR_Addr = 18'h00100; iWR_Data = 16'hABCD;
    @(negedge mCLK);
    iWR_Valid = 1'b0;
    check("wr_level1", 32'(oFIFO_Level), 32'd1);
    low_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge mCLK);
      if (oSRAM_WE_N === 1'b0) begin
        low_cnt++;
        check("wr_addr",  32'(oSRAM_ADDR), 32'h00100);
        check("wr_dq",    32'(oSRAM_DQ), 32'hABCD);
        check("wr_dq_oe", 32'(oSRAM_DQ_OE), 32'h1);
      end
    end
    check("wr_low_cycles", 32'(low_cnt), 32'd1);
    check("wr_pulses",     32'(we_pulses - p0), 32'd1);
    check("wr_level0",     32'(oFIFO_Level), 32'd0);
    check("wr_mem",        32'(mem[10'h100]), 32'hABCD);
    iRead_EN = 1'b1; iAddress = 20'h00100;
    @(negedge mCLK);
    iRead_EN = 1'b0;
    repeat (2) @(negedge mCLK);
    check("wr_readback", 32'(rgb), 32'(RGB_ABC));

    // ---- FIFO fills while the display reads continuously ----
    p0 = we_pulses;
    iRead_EN = 1'b1; iAddress = 20'h00010;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_level%0d", i), 32'(oFIFO_Level), 32'(i < 4 ? i : 4));
      check($sformatf("bp_ready%0d", i), 32'(oWR_Ready), 32'(i < 4));
      iWR_Valid = 1'b1; iWR_Addr = ADDR_W'(18'h00200 + i); iWR_Data = 16'(16'h1000 + i);
      @(negedge mCLK);
    end
    iWR_Valid = 1'b0;
    check("bp_level_full", 32'(oFIFO_Level), 32'd4);
    repeat (3) @(negedge mCLK);
    check("bp_no_strobe", 32'(we_pulses - p0), 32'd0);
    iRead_EN = 1'b0;
    wait_drain("bp_drain", busy);
    check("bp_pulses", 32'(we_pulses - p0), 32'd4);
    check("bp_busy",   32'(busy), 32'd12);
    check("bp_mem0",   32'(mem[10'h200]), 32'h1000);
    check("bp_mem3",   32'(mem[10'h203]), 32'h1003);
    check("bp_mem4",   32'(mem[10'h204]), 32'h0000);

    // ---- read arrives in WR_SETUP: write yields ----
    iWR_Valid = 1'b1; iWR_Addr = 18'h00300; iWR_Data = 16'h1234;
    @(negedge mCLK);
    iWR_Valid = 1'b0;
    p0 = we_pulses;
    wait_setup("ab_setup");
    iRead_EN = 1'b1; iAddress = 20'h00010;
    @(negedge mCLK);
    iRead_EN = 1'b0;
    check("ab_no_strobe", 32'(we_pulses - p0), 32'd0);
    check("ab_level",     32'(oFIFO_Level), 32'd1);
    check("ab_dq_oe",     32'(oSRAM_DQ_OE), 32'd0);
    repeat (2) @(negedge mCLK);
    check("ab_rgb",  32'(rgb), 32'(RGB_R));
    check("ab_coll", 32'(oCollision), 32'd0);
    wait_drain("ab_drain", busy);
    check("ab_pulses", 32'(we_pulses - p0), 32'd1);
    check("ab_mem",    32'(mem[10'h300]), 32'h1234);

    // ---- read arrives in WR_STROBE: collision ----
    iWR_Valid = 1'b1; iWR_Addr = 18'h00301; iWR_Data = 16'h5555;
    @(negedge mCLK);
    iWR_Valid = 1'b0;
    p0 = we_pulses;
    wait_setup("co_setup");
    @(negedge mCLK);
    check("co_in_strobe", 32'(oSRAM_WE_N), 32'd0);
    iRead_EN = 1'b1; iAddress = 20'h00013;
    @(negedge mCLK);
    iRead_EN = 1'b0;
    check("co_flag", 32'(oCollision), 32'd1);
    repeat (2) @(negedge mCLK);
    check("co_rgb_black", 32'(rgb), 32'h0);
    wait_drain("co_drain", busy);
    check("co_pulses", 32'(we_pulses - p0), 32'd1);
    check("co_mem",    32'(mem[10'h301]), 32'h5555);
    check("co_sticky", 32'(oCollision), 32'd1);
    iClr_Status = 1'b1;
    @(negedge mCLK);
    iClr_Status = 1'b0;
    check("co_cleared", 32'(oCollision), 32'd0);

    // ---- asynchronous reset during WR_STROBE ----
    iRead_EN = 1'b1; iAddress = 20'h00013;
    iWR_Valid = 1'b1; iWR_Addr = 18'h00302; iWR_Data = 16'h0F0F;
    @(negedge mCLK);
    iRead_EN = 1'b0; iWR_Valid = 1'b0;
    repeat (2) @(negedge mCLK);
    check("mr_pre_we_n",  32'(oSRAM_WE_N), 32'd0);
    check("mr_pre_rgb",   32'(rgb), 32'(RGB_W));
    check("mr_pre_level", 32'(oFIFO_Level), 32'd1);
    iRST_N = 1'b0;
    #1;
    check("mr_we_n",  32'(oSRAM_WE_N), 32'd1);
    check("mr_dq_oe", 32'(oSRAM_DQ_OE), 32'd0);
    check("mr_rgb",   32'(rgb), 32'h0);
    check("mr_level", 32'(oFIFO_Level), 32'd0);
    check("mr_ready", 32'(oWR_Ready), 32'd1);
    check("mr_addr",  32'(oSRAM_ADDR), 32'h0);
    @(negedge mCLK);
    iRST_N = 1'b1;
    p0 = we_pulses;
    repeat (8) @(negedge mCLK);
    check("mr_discarded", 32'(we_pulses - p0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
